rr_mux_reg: RTL and testbench

//  Parametrised N-channel, W-bit round-robin multiplexer with valid/ready handshakes and a registered output.

---
 rtl/rr_mux_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/rr_mux_reg.sv | 177 +++++++++++++++++
 tb/tb_rr_mux_reg.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered mux (rr_mux_reg).
// Packet-lock mode is enabled by defining RR_MUX_PKT_EN.
package rr_mux_pkg;

  localparam int RR_N_DEF    = 4;
  localparam int RR_W_DEF    = 8;
  // Decode width for onehot(); channel count must stay below RR_MAX_N.
  localparam int RR_MAX_N    = 256;
  localparam int RR_MAX_SELW = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic logic [RR_MAX_N-1:0] onehot(input logic [RR_MAX_SELW-1:0] sel);
    logic [RR_MAX_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request scanning from ptr upwards
// with wrap; mask_en restricts eligibility to the single channel mask_ch.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N    = RR_N_DEF,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mask_en,
  input  logic [SELW-1:0] mask_ch,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [N-1:0] elig_s;

  // Restrict eligibility to the locked channel when masking is active.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_en) begin
        elig_s[i] = req[i] & (mask_ch == SELW'(i));
      end else begin
        elig_s[i] = req[i];
      end
    end
  end

  // Rotating priority scan; sum never exceeds 2N-2, so one subtraction wraps it.
  always_comb begin
    logic [SELW:0]   sum_v;
    logic [SELW-1:0] idx_v;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum_v   = '0;
    idx_v   = '0;
    for (int k = 0; k < N; k++) begin
      sum_v = {1'b0, ptr} + (SELW+1)'(k);
      if (sum_v >= (SELW+1)'(N)) begin
        idx_v = SELW'(sum_v - (SELW+1)'(N));
      end else begin
        idx_v = sum_v[SELW-1:0];
      end
      if (!gnt_vld && elig_s[idx_v]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_v;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel round-robin mux with valid/ready handshakes and a registered output stage.
// Define RR_MUX_PKT_EN for packet-lock mode (adds in_last/out_last and the ARB/LOCK FSM).
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int N    = RR_N_DEF,
  parameter int W    = RR_W_DEF,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef RR_MUX_PKT_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel,
  output logic [N-1:0]    out_grant
);

  logic [W-1:0]          out_data_r;
  logic                  out_valid_r;
  logic [SELW-1:0]       out_sel_r;
  logic [SELW-1:0]       ptr_r;
  logic [SELW-1:0]       ptr_nx_s;
  logic [SELW-1:0]       gnt_idx_s;
  logic                  gnt_vld_s;
  logic                  load_s;
  logic                  accept_s;
  logic                  ptr_adv_s;
  logic                  mask_en_s;
  logic [SELW-1:0]       mask_ch_s;
  logic [W-1:0]          sel_data_s;
  logic [RR_MAX_N-1:0]   grant_wide_s;

  assign load_s   = ~out_valid_r | out_ready;
  assign accept_s = load_s & gnt_vld_s;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_r),
    .mask_en (mask_en_s),
    .mask_ch (mask_ch_s),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

`ifdef RR_MUX_PKT_EN
  state_t          state_r;
  state_t          state_nx_s;
  logic [SELW-1:0] lock_ch_r;
  logic            out_last_r;
  logic            sel_last_s;

  assign mask_en_s = (state_r == LOCK);
  assign mask_ch_s = lock_ch_r;
  assign ptr_adv_s = accept_s & sel_last_s;
  assign out_last  = out_last_r;

  // Last flag of the winning channel.
  always_comb begin
    sel_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        sel_last_s = in_last[i];
      end else begin
        sel_last_s = sel_last_s;
      end
    end
  end

  // Packet lock next-state: a non-last beat locks, a last beat releases.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ARB: begin
        if (accept_s && !sel_last_s) state_nx_s = LOCK;
        else                          state_nx_s = ARB;
      end
      LOCK: begin
        if (accept_s && sel_last_s) state_nx_s = ARB;
        else                        state_nx_s = LOCK;
      end
      default: state_nx_s = ARB;
    endcase
  end

  // FSM state, locked channel and registered last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB;
      lock_ch_r  <= '0;
      out_last_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        lock_ch_r  <= gnt_idx_s;
        out_last_r <= sel_last_s;
      end
    end
  end
`else
  assign mask_en_s = 1'b0;
  assign mask_ch_s = '0;
  assign ptr_adv_s = accept_s;
`endif

  // Winner data select and next pointer (winner+1 with wrap at N).
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        sel_data_s = in_data[i*W +: W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    if (gnt_idx_s == SELW'(N-1)) begin
      ptr_nx_s = '0;
    end else begin
      ptr_nx_s = gnt_idx_s + SELW'(1);
    end
  end

  // Ready goes only to the winner, and only when the output register can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && accept_s && (gnt_idx_s == SELW'(i))) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else begin
      if (accept_s) begin
        out_data_r  <= sel_data_s;
        out_sel_r   <= gnt_idx_s;
        out_valid_r <= 1'b1;
      end else if (load_s) begin
        out_valid_r <= 1'b0;
      end
      if (ptr_adv_s) begin
        ptr_r <= ptr_nx_s;
      end
    end
  end

  // Grant decode; blanked if the decode ever lands outside the channel range.
  always_comb begin
    grant_wide_s = onehot(RR_MAX_SELW'(out_sel_r));
    if (out_valid_r && !(|grant_wide_s[RR_MAX_N-1:N])) begin
      out_grant = grant_wide_s[N-1:0];
    end else begin
      out_grant = '0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: behavioural model for the N=4 instance checked every
// cycle, plus directed literal checks (N=3 instance included). Covers RR_MUX_PKT_EN when defined.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  in_last = 4'b1111;
  logic        out_last;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_sel;
  logic [3:0]  out_grant;

  logic [23:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [2:0]  in_last3 = 3'b111;
  logic        out_last3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [1:0]  out_sel3;
  logic [2:0]  out_grant3;

  int checks = 0;
  int failures = 0;

  // model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_ptr;
  bit         m_locked;
  int         m_lockch;
  bit         m_last;

  always #5 clk = ~clk;

  rr_mux_reg #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef RR_MUX_PKT_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_grant(out_grant)
  );

  rr_mux_reg #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef RR_MUX_PKT_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sel(out_sel3), .out_grant(out_grant3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p, input bit locked, input int lch);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (v[i] && (!locked || i == lch)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0;
    m_locked = 1'b0; m_lockch = 0; m_last = 1'b0;
  endtask

  task automatic model_step();
    int w;
    bit load;
    if (!rst_n) begin
      model_reset();
    end else begin
      load = !m_valid || out_ready;
      w = pick(in_valid, m_ptr, m_locked, m_lockch);
      if (load && w >= 0) begin
        m_data = in_data[w*8 +: 8];
        m_sel = w;
        m_valid = 1'b1;
`ifdef RR_MUX_PKT_EN
        m_last = in_last[w];
        if (!in_last[w]) begin
          m_locked = 1'b1; m_lockch = w;
        end else begin
          m_locked = 1'b0; m_ptr = (w + 1) % 4;
        end
`else
        m_ptr = (w + 1) % 4;
`endif
      end else if (load) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    int w;
    bit load;
    logic [3:0] exp_rdy;
    logic [3:0] exp_gnt;
    load = !m_valid || out_ready;
    w = pick(in_valid, m_ptr, m_locked, m_lockch);
    exp_rdy = (rst_n && load && w >= 0) ? (4'b0001 << w) : 4'b0000;
    exp_gnt = m_valid ? (4'b0001 << m_sel) : 4'b0000;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("out_grant", 32'(out_grant), 32'(exp_gnt));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef RR_MUX_PKT_EN
    chk("out_last", 32'(out_last), 32'(m_last));
`endif
  endtask

  // negedge: compare; posedge: model follows the edge; return just after it
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_all(input logic [7:0] b);
    in_data = {8'h30 + b, 8'h20 + b, 8'h10 + b, b};
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_out_grant", 32'(out_grant), 32'h0);

    // 1: all valid, full throughput
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_all(8'(k));
      tick();
      chk("t1_sel", 32'(out_sel), 32'(k % 4));
      chk("t1_data", 32'(out_data), 32'(8'h10 * (k % 4) + k));
      chk("t1_valid", 32'(out_valid), 32'h1);
    end

    // 2: sparse requests from ptr=0
    in_valid = 4'b0000;
    do_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      drive_all(8'(8'h40 + k));
      #1;
      chk("t2_ready", 32'(in_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      tick();
      chk("t2_sel", 32'(out_sel), (k % 2 == 0) ? 32'h1 : 32'h3);
    end

    // 3: stall holding A5 from ch2
    in_valid = 4'b0000;
    do_reset();
    in_data = {8'h3C, 8'hA5, 8'h1C, 8'h0C};
    in_valid = 4'b0100;
    tick();
    chk("t3_load_data", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_data", 32'(out_data), 32'hA5);
      chk("t3_hold_sel", 32'(out_sel), 32'h2);
      chk("t3_hold_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_resume_sel", 32'(out_sel), 32'h3);
    chk("t3_resume_data", 32'(out_data), 32'h3C);
    tick();
    chk("t3_next_sel", 32'(out_sel), 32'h0);
    chk("t3_next_data", 32'(out_data), 32'h0C);

    // 4: N=3 wrap
    in_valid = 4'b0000;
    do_reset();
    in_data3 = {8'hC2, 8'hC1, 8'hC0};
    in_valid3 = 3'b100;
    tick();
    chk("t4_sel_a", 32'(out_sel3), 32'h2);
    chk("t4_gnt_a", 32'(out_grant3), 32'h4);
    chk("t4_data_a", 32'(out_data3), 32'hC2);
    in_valid3 = 3'b001;
    tick();
    chk("t4_sel_b", 32'(out_sel3), 32'h0);
    chk("t4_gnt_b", 32'(out_grant3), 32'h1);
    in_valid3 = 3'b111;
    tick();
    chk("t4_sel_c", 32'(out_sel3), 32'h1);
    in_valid3 = 3'b000;
    tick();
    chk("t4_drain", 32'(out_valid3), 32'h0);
    chk("t4_drain_gnt", 32'(out_grant3), 32'h0);

`ifdef RR_MUX_PKT_EN
    // 5: packet lock on ch1 while ch0/ch2 request
    do_reset();
    in_last = 4'b1111;
    in_valid = 4'b0001;
    drive_all(8'h50);
    tick();
    chk("t5_pre_sel", 32'(out_sel), 32'h0);
    in_valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      drive_all(8'(8'h60 + k));
      in_last = (k < 2) ? 4'b1101 : 4'b1111;
      tick();
      chk("t5_sel", 32'(out_sel), (k < 3) ? 32'h1 : 32'h2);
      if (k < 3) chk("t5_last", 32'(out_last), (k == 2) ? 32'h1 : 32'h0);
      else       chk("t5_last", 32'(out_last), 32'h1);
    end
    in_valid = 4'b0000;
    in_last = 4'b1111;
`endif

    // 6: async reset mid-stream
    in_valid = 4'b0000;
    do_reset();
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      drive_all(8'(8'h70 + k));
      tick();
    end
    chk("t6_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_grant", 32'(out_grant), 32'h0);
    chk("t6_async_ready", 32'(in_ready), 32'h0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_restart_sel", 32'(out_sel), 32'h0);
    chk("t6_restart_valid", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
